// File: rtl/rr_arb4_mux_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter/mux.
package rr_arb4_mux_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Turn a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/rr_arb4_mux_pick4.sv
// Rotating-priority picker: the first set req bit at or after ptr, wrapping mod 4.
module rr_pick4
  import rr_arb4_mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the closest hit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_mux.sv
// 4-requester round-robin arbiter with burst limit and 1-bit data mux.
module rr_arb4_mux
  import rr_arb4_mux_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic               out_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [SEL_W-1:0]   ptr_d;
  logic [SEL_W-1:0]   pick_ptr;
  logic [CNT_W-1:0]   cnt_inc;
  logic               xfer;
  logic               burst_done;
  logic               rel;
  logic               found;
  logic [SEL_W-1:0]   idx;

  assign busy      = (state_q == GRANT);
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = busy & req[sel_q];
  // Data is never registered; the requester holds din while stalled.
  assign out_data  = din[sel_q];

  assign xfer       = out_valid & out_ready;
  assign cnt_inc    = cnt_q + 1'b1;
  assign burst_done = xfer && (cnt_inc == CNT_W'(MAX_BURST));
  assign rel        = busy && (!req[sel_q] || burst_done);

  // On release the current owner drops to lowest priority; while idle use the stored pointer.
  assign ptr_d    = sel_q + 1'b1;
  assign pick_ptr = busy ? ptr_d : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (idx)
  );

  // FSM, grant registers, rotation pointer and burst counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= GRANT;
            gnt_q   <= idx2oh(idx);
            sel_q   <= idx;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            // Re-arbitrate on the release edge so back-to-back grants have no bubble.
            ptr_q <= ptr_d;
            cnt_q <= '0;
            if (found) begin
              gnt_q <= idx2oh(idx);
              sel_q <= idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end else if (xfer) begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4_mux.sv
// Scoreboard bench for rr_arb4_mux: directed vectors push expected transfers,
// a negedge monitor pops and compares whenever a transfer is presented.
module tb_rr_arb4_mux;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  rr_arb4_mux #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] s, input logic d, input int n);
    exp_t e;
    e.gnt  = g;
    e.sel  = s;
    e.data = d;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  // Monitor: grant sanity every cycle, scoreboard compare on each presented transfer.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    checks++;
    if (!($onehot0(gnt) && (busy ? (gnt == (4'b0001 << sel)) : (gnt == 4'b0000)))) begin
      failures++;
      $display("FAIL gnt_sanity: gnt=%b sel=%0d busy=%b", gnt, sel, busy);
    end
    if (out_valid && out_ready) begin
      a.gnt  = gnt;
      a.sel  = sel;
      a.data = out_data;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected: gnt=%b sel=%0d data=%b", gnt, sel, out_data);
      end else begin
        e = sb_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL xfer: got gnt=%b sel=%0d data=%b expected gnt=%b sel=%0d data=%b",
                   a.gnt, a.sel, a.data, e.gnt, e.sel, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 2 cycles with all requests high.
    rst = 1'b1; req = 4'hF; din = 4'h0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_busy", 32'(busy), 32'h1);
    req = 4'h0;
    tick();
    chk("drop_idle_gnt", 32'(gnt), 32'h0);
    chk("drop_idle_busy", 32'(busy), 32'h0);

    // Single requester 2: burst of 4, re-granted with no gap; 6 transfers total.
    req = 4'b0100; din = 4'b0100; out_ready = 1'b1;
    push(4'b0100, 2'd2, 1'b1, 6);
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'(sel), 32'h2);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'h1);
    repeat (6) tick();
    req = 4'h0; out_ready = 1'b0;
    tick();
    chk("single_idle", 32'(busy), 32'h0);

    // Fairness: all requesting, grants 0,1,2,3,0 with 4 transfers each.
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'hF; din = 4'b0101; out_ready = 1'b1;
    push(4'b0001, 2'd0, 1'b1, 4);
    push(4'b0010, 2'd1, 1'b0, 4);
    push(4'b0100, 2'd2, 1'b1, 4);
    push(4'b1000, 2'd3, 1'b0, 4);
    push(4'b0001, 2'd0, 1'b1, 4);
    repeat (21) tick();
    chk("fair_next_gnt", 32'(gnt), 32'h2);
    req = 4'h0; out_ready = 1'b0;
    tick();
    chk("fair_idle", 32'(gnt), 32'h0);

    // Backpressure: requester 1 stalled 10 cycles, then finishes a full burst before 3.
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1010; din = 4'b0010; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_gnt", 32'(gnt), 32'h2);
      chk("bp_valid", 32'(out_valid), 32'h1);
      tick();
    end
    push(4'b0010, 2'd1, 1'b1, 4);
    push(4'b1000, 2'd3, 1'b0, 2);
    out_ready = 1'b1;
    repeat (6) tick();
    req = 4'h0; out_ready = 1'b0;
    tick();
    chk("bp_idle", 32'(gnt), 32'h0);

    // Early drop: requester 1 leaves after 2 transfers, 3 takes over, pointer moves to 2.
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1010; din = 4'b0000; out_ready = 1'b1;
    push(4'b0010, 2'd1, 1'b0, 2);
    tick(); tick(); tick();
    req = 4'b1000;
    tick();
    out_ready = 1'b0;
    chk("drop_gnt", 32'(gnt), 32'h8);
    chk("drop_sel", 32'(sel), 32'h3);
    chk("drop_ptr", 32'(dut.ptr_q), 32'h2);
    req = 4'h0;
    tick();
    chk("drop_end_idle", 32'(busy), 32'h0);

    // Mid-burst reset: requester 2 loses its grant, no rotation credit.
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0100; din = 4'b0100; out_ready = 1'b1;
    push(4'b0100, 2'd2, 1'b1, 2);
    tick(); tick();
    rst = 1'b1; req = 4'b0101;
    tick();
    chk("mrst_gnt", 32'(gnt), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0; out_ready = 1'b0;
    tick();
    chk("mrst_regnt", 32'(gnt), 32'h1);
    chk("mrst_sel", 32'(sel), 32'h0);
    chk("mrst_ptr", 32'(dut.ptr_q), 32'h0);
    req = 4'h0;
    tick(); tick();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb4_mux.md
RR_ARB4_MUX -- requirements
Module: rr_arb4_mux

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum transfers per grant (legal range 1..16).
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: req  in  4  request per requester 0..3; a requester holds req high until served.
REQ-005 Port: din  in  4  data bit per requester; bit i belongs to requester i.
REQ-006 Port: out_ready  in  1  downstream ready.
REQ-007 Port: gnt  out  4  one-hot grant, registered; 4'b0000 when idle.
REQ-008 Port: sel  out  2  registered select of the granted requester (sel[1]=s1, sel[0]=s0).
REQ-009 Port: out_valid  out  1  downstream valid.
REQ-010 Port: out_data  out  1  din[sel], combinational 4:1 select.
REQ-011 Port: busy  out  1  high in GRANT state.

Function
REQ-012 States SHALL be exactly IDLE and GRANT.
REQ-013 Rotation pointer ptr (2 bits) SHALL define priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 IDLE: any req bit high at edge N -> GRANT at N+1, with gnt/sel = first requester in rotation order and burst count = 0; one-cycle grant latency.
REQ-015 IDLE: req = 0 -> remain IDLE, gnt = 0.
REQ-016 out_valid SHALL equal busy AND req[sel], combinationally.
REQ-017 Transfer SHALL occur on an edge where out_valid AND out_ready; each transfer increments burst count (width ceil(log2(MAX_BURST+1))).
REQ-018 Release SHALL occur on an edge where (a) req[sel] = 0 or (b) a transfer makes count equal MAX_BURST.
REQ-019 On release: ptr <= sel+1 mod 4; the same edge SHALL re-arbitrate over current req using the new ptr, giving no idle bubble; count <= 0.
REQ-020 A released requester SHALL have lowest priority; it is re-granted only if no other req is high.
REQ-021 On release with req = 0 (or only the released requester's req, now low): next state IDLE, gnt = 0.
REQ-022 out_valid high with out_ready low SHALL hold gnt, sel and count unchanged indefinitely (no timeout).
REQ-023 The block SHALL NOT register din; requesters hold din stable while their out_valid is high and out_ready is low.
REQ-024 gnt SHALL always be one-hot or zero and consistent with sel when busy.

Reset
REQ-025 rst high at an edge SHALL force: state IDLE, gnt 0, sel 0, ptr 0, count 0, busy 0; out_valid therefore 0.
REQ-026 rst SHALL take priority over every other event, including a transfer on the same edge; reset mid-burst discards the grant with no rotation credit.
REQ-027 The first arbitration after reset SHALL start at requester 0.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, GRANT), NUM_REQ = 4 and SEL_W = 2.
REQ-029 Rotating-priority selection SHALL live in one combinational sub-module, rr_pick4 (inputs req, ptr; outputs found, idx).
REQ-030 The top SHALL contain the FSM, count, ptr and registers, plus the output data select.

Verification
REQ-031 Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, sel=0, out_valid=0, busy=0; after rst drops, gnt=4'b0001 one cycle later.
REQ-032 Single requester: req=4'b0100, din=4'b0100, out_ready=1 -> next cycle gnt=4'b0100, sel=2, out_valid=1, out_data=1; after 4 transfers it is re-granted with count reset and no gap.
REQ-033 Fairness: req=4'b1111, out_ready=1, MAX_BURST=4 -> grants 0,1,2,3,0, four cycles each, no idle cycle between them.
REQ-034 Backpressure: granted requester 1, out_ready=0 for 10 cycles -> gnt=4'b0010 and out_valid=1 throughout, count unchanged, no rotation.
REQ-035 Early drop: requester 1 granted, req[1] falls after 2 transfers with req[3]=1 -> gnt=4'b1000 on the next edge, ptr=2.
REQ-036 Mid-burst reset: rst pulsed during requester 2's burst with out_valid=out_ready=1 -> gnt=0 next edge; after release, requester 0 wins if req=4'b0101.
